frame_sync_gen: RTL and testbench
=================================

Name: frame_sync_gen

Overview:
- Parametrised frame synchroniser for the digital receive chain. It sits between the bit decision stage and the deframer/decoder.
- Searches the decided bit stream for a configurable sync word, in either polarity, with a configurable Hamming-error tolerance.
- After acquisition it flywheels frame by frame: checks each expected sync word, forwards polarity-corrected payload bits with frame markers, and drops lock after a set number of consecutive sync misses.

Parameters:
SYNC_LEN, 7, sync word length in bits (2..32).
SYNC_WORD, 7'b1110010, sync pattern; MSB is received first.
MAX_ERR, 0, maximum Hamming distance still accepted as a match.
POL_DETECT, 1, 1 = also accept ~SYNC_WORD as inverted polarity; 0 = positive polarity only.
FRAME_BITS, 64, payload bits between consecutive sync words (>=1).
MISS_LIMIT, 3, consecutive failed sync checks that cause loss of lock (>=1).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_rx_start_pulse  in  1  arms the block: IDLE->SEARCH
i_rx_end_pulse  in  1  end of burst: any locked state->SEARCH
i_bit_valid  in  1  strobe for i_bit_data
i_bit_data  in  1  decided bit
o_sync_valid_pulse  out  1  1-cycle pulse on acquisition (SEARCH->LOCK)
o_lost_pulse  out  1  1-cycle pulse when lock is lost through misses
o_bit_data  out  1  polarity-corrected payload bit
o_bit_valid  out  1  strobe for o_bit_data
o_frame_start  out  1  qualifies the first payload bit of each frame
o_frame_end  out  1  qualifies the last payload bit of each frame
o_locked  out  1  high in the PAYLOAD and CHECK states
o_polarity  out  1  0 = normal, 1 = inverted; valid while o_locked
o_sync_err  out  clog2(SYNC_LEN+1)  Hamming distance of the last accepted sync word

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; shift register, counters and every output cleared to 0.
  - Takes priority over all other inputs, including mid-frame.
- Shift register sr[SYNC_LEN-1:0]:
  - On every i_bit_valid, in SEARCH or CHECK: sr <= {sr[SYNC_LEN-2:0], i_bit_data}.
  - Cleared on entry to SEARCH and on entry to CHECK.
- Match evaluation (combinational):
  - Operand: cand = {sr[SYNC_LEN-2:0], i_bit_data}.
  - dp = popcount(cand ^ SYNC_WORD); dn = popcount(cand ^ ~SYNC_WORD).
  - pos_hit = dp<=MAX_ERR. neg_hit = POL_DETECT && dn<=MAX_ERR.
  - If both hit, positive polarity wins.
- SEARCH:
  - A match is only recognised once at least SYNC_LEN bits have been shifted since entry; a fill counter enforces this.
  - On i_bit_valid with pos_hit or neg_hit: o_polarity <= neg_hit&&!pos_hit; o_sync_err <= the corresponding distance; o_sync_valid_pulse=1 for 1 cycle; state->PAYLOAD with payload counter=0.
- PAYLOAD:
  - Each i_bit_valid produces one output bit, registered 1 cycle later: o_bit_valid=1, o_bit_data=i_bit_data^o_polarity.
  - o_frame_start=1 on count 0; o_frame_end=1 on count FRAME_BITS-1.
  - After bit FRAME_BITS-1: state->CHECK.
  - o_bit_valid is 0 in every other cycle and state; o_bit_data holds its last value.
- CHECK:
  - Collects SYNC_LEN bits. These are not forwarded.
  - On the SYNC_LEN-th bit, compare against the locked polarity only.
    - Match: miss counter=0, o_sync_err updated, state->PAYLOAD.
    - Miss: miss counter+1. If it reaches MISS_LIMIT: o_lost_pulse=1 for 1 cycle, state->SEARCH. Otherwise state->PAYLOAD (flywheel), with o_sync_err unchanged.
  - A sync word that matches only in the opposite polarity counts as a miss.
- IDLE: ignores bits. i_rx_start_pulse -> SEARCH. i_rx_start_pulse in any other state is ignored.
- i_rx_end_pulse:
  - In PAYLOAD or CHECK: state->SEARCH next cycle, miss counter cleared, o_locked=0, no o_lost_pulse.
  - A bit arriving in the same cycle is dropped.
  - In IDLE or SEARCH: no effect.
- Registration: all outputs are registered. Minimum latency from input bit to output bit is 1 cycle.
- Back-to-back bits: i_bit_valid may be high on consecutive cycles.

Test Plan:
- Start pulse, then 1110010 followed by 64 bits alternating 1,0 -> o_sync_valid_pulse 1 cycle after the last sync bit; o_polarity=0; 64 o_bit_valid with first data 1; o_frame_start on bit 0; o_frame_end on bit 63.
- Send 0001101 then payload of all 0 -> o_polarity=1; all 64 output bits=1. Repeat with POL_DETECT=0 -> stays in SEARCH, no output.
- MAX_ERR=1, send 1110011 -> lock, o_sync_err=1. Send 1110001 (2 errors) -> no lock.
- Lock, then 3 frames with corrupted sync (MISS_LIMIT=3) -> payload of frames 2 and 3 still forwarded; o_lost_pulse after the 3rd bad sync; o_locked=0. A good sync after 2 misses resets the miss counter.
- i_rx_end_pulse at payload bit 20 -> no further o_bit_valid; SEARCH re-acquires on the next sync word without a new start pulse.
- rst asserted mid-PAYLOAD -> all outputs 0 next cycle, state IDLE; bits ignored until i_rx_start_pulse. Also check a sync pattern inside the first SYNC_LEN-1 bits after entry is not falsely matched.

Source files
------------

// File: rtl/frame_sync_gen.sv
// Frame synchroniser: searches for a sync word (either polarity, Hamming tolerant),
// then flywheels frame by frame, forwarding polarity-corrected payload bits.
//   state   | meaning
//   IDLE    | disarmed, bits ignored
//   SEARCH  | sliding-window hunt for the sync word
//   PAYLOAD | forwarding FRAME_BITS payload bits
//   CHECK   | collecting the expected sync word of the next frame
module frame_sync_gen #(
  parameter int                  SYNC_LEN   = 7,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD  = 7'b1110010,
  parameter int                  MAX_ERR    = 0,
  parameter int                  POL_DETECT = 1,
  parameter int                  FRAME_BITS = 64,
  parameter int                  MISS_LIMIT = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_rx_start_pulse,
  input  logic                            i_rx_end_pulse,
  input  logic                            i_bit_valid,
  input  logic                            i_bit_data,
  output logic                            o_sync_valid_pulse,
  output logic                            o_lost_pulse,
  output logic                            o_bit_data,
  output logic                            o_bit_valid,
  output logic                            o_frame_start,
  output logic                            o_frame_end,
  output logic                            o_locked,
  output logic                            o_polarity,
  output logic [$clog2(SYNC_LEN+1)-1:0]   o_sync_err
);

  localparam int ERR_W  = $clog2(SYNC_LEN + 1);
  localparam int BCNT_W = $clog2(SYNC_LEN);
  localparam int PCNT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int MISS_W = (MISS_LIMIT > 1) ? $clog2(MISS_LIMIT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_PAYLOAD, S_CHECK} state_t;

  state_t              state_q, state_d;
  // Only the SYNC_LEN-1 youngest bits are kept; the incoming bit completes the window.
  logic [SYNC_LEN-2:0] sr_q, sr_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic                pol_q, pol_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic                sync_pulse_q, sync_pulse_d;
  logic                lost_q, lost_d;
  logic                bit_data_q, bit_data_d;
  logic                bit_valid_q, bit_valid_d;
  logic                fstart_q, fstart_d;
  logic                fend_q, fend_d;
  logic                locked_q, locked_d;

  logic [SYNC_LEN-1:0] cand;
  logic [ERR_W-1:0]    dp, dn;
  logic                pos_hit, neg_hit, lock_hit;
  logic                win_full;

  function automatic logic [ERR_W-1:0] popcnt(input logic [SYNC_LEN-1:0] v);
    logic [ERR_W-1:0] c;
    c = '0;
    for (int i = 0; i < SYNC_LEN; i++) c = c + ERR_W'(v[i]);
    return c;
  endfunction

  assign cand     = {sr_q, i_bit_data};
  assign dp       = popcnt(cand ^ SYNC_WORD);
  assign dn       = popcnt(cand ^ ~SYNC_WORD);
  assign pos_hit  = (int'(dp) <= MAX_ERR);
  assign neg_hit  = (POL_DETECT != 0) && (int'(dn) <= MAX_ERR);
  assign lock_hit = pol_q ? (int'(dn) <= MAX_ERR) : pos_hit;
  assign win_full = (bcnt_q == BCNT_W'(SYNC_LEN - 1));

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    bcnt_d       = bcnt_q;
    pcnt_d       = pcnt_q;
    miss_d       = miss_q;
    pol_d        = pol_q;
    err_d        = err_q;
    bit_data_d   = bit_data_q;
    sync_pulse_d = 1'b0;
    lost_d       = 1'b0;
    bit_valid_d  = 1'b0;
    fstart_d     = 1'b0;
    fend_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_rx_start_pulse) begin
          state_d = S_SEARCH;
          sr_d    = '0;
          bcnt_d  = '0;
        end
      end
      S_SEARCH: begin
        if (i_bit_valid) begin
          sr_d = cand[SYNC_LEN-2:0];
          if (!win_full) bcnt_d = bcnt_q + BCNT_W'(1);
          if (win_full && (pos_hit || neg_hit)) begin
            state_d      = S_PAYLOAD;
            pcnt_d       = '0;
            miss_d       = '0;
            pol_d        = !pos_hit;
            err_d        = pos_hit ? dp : dn;
            sync_pulse_d = 1'b1;
          end
        end
      end
      S_PAYLOAD: begin
        if (i_rx_end_pulse) begin
          state_d = S_SEARCH;
          sr_d    = '0;
          bcnt_d  = '0;
          miss_d  = '0;
        end else if (i_bit_valid) begin
          bit_valid_d = 1'b1;
          bit_data_d  = i_bit_data ^ pol_q;
          fstart_d    = (pcnt_q == '0);
          fend_d      = (pcnt_q == PCNT_W'(FRAME_BITS - 1));
          if (pcnt_q == PCNT_W'(FRAME_BITS - 1)) begin
            state_d = S_CHECK;
            sr_d    = '0;
            bcnt_d  = '0;
          end else begin
            pcnt_d = pcnt_q + PCNT_W'(1);
          end
        end
      end
      S_CHECK: begin
        if (i_rx_end_pulse) begin
          state_d = S_SEARCH;
          sr_d    = '0;
          bcnt_d  = '0;
          miss_d  = '0;
        end else if (i_bit_valid) begin
          sr_d = cand[SYNC_LEN-2:0];
          if (!win_full) begin
            bcnt_d = bcnt_q + BCNT_W'(1);
          end else if (lock_hit) begin
            miss_d  = '0;
            err_d   = pol_q ? dn : dp;
            state_d = S_PAYLOAD;
            pcnt_d  = '0;
          end else if (miss_q == MISS_W'(MISS_LIMIT - 1)) begin
            lost_d  = 1'b1;
            state_d = S_SEARCH;
            sr_d    = '0;
            bcnt_d  = '0;
            miss_d  = '0;
          end else begin
            miss_d  = miss_q + MISS_W'(1);
            state_d = S_PAYLOAD;
            pcnt_d  = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    locked_d = (state_d == S_PAYLOAD) || (state_d == S_CHECK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sr_q         <= '0;
      bcnt_q       <= '0;
      pcnt_q       <= '0;
      miss_q       <= '0;
      pol_q        <= 1'b0;
      err_q        <= '0;
      sync_pulse_q <= 1'b0;
      lost_q       <= 1'b0;
      bit_data_q   <= 1'b0;
      bit_valid_q  <= 1'b0;
      fstart_q     <= 1'b0;
      fend_q       <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      bcnt_q       <= bcnt_d;
      pcnt_q       <= pcnt_d;
      miss_q       <= miss_d;
      pol_q        <= pol_d;
      err_q        <= err_d;
      sync_pulse_q <= sync_pulse_d;
      lost_q       <= lost_d;
      bit_data_q   <= bit_data_d;
      bit_valid_q  <= bit_valid_d;
      fstart_q     <= fstart_d;
      fend_q       <= fend_d;
      locked_q     <= locked_d;
    end
  end

  assign o_sync_valid_pulse = sync_pulse_q;
  assign o_lost_pulse       = lost_q;
  assign o_bit_data         = bit_data_q;
  assign o_bit_valid        = bit_valid_q;
  assign o_frame_start      = fstart_q;
  assign o_frame_end        = fend_q;
  assign o_locked           = locked_q;
  assign o_polarity         = pol_q;
  assign o_sync_err         = err_q;

endmodule

// File: tb/tb_frame_sync_gen.sv
// Bench for frame_sync_gen: three instances (default, POL_DETECT=0, MAX_ERR=1) share stimulus;
// payload output of the default instance is checked against a scoreboard queue.
module tb_frame_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, st, en, bv, bd;
  logic [2:0] sv, lost, od, ov, fs, fe, lk, pl;
  logic [2:0][2:0] er;

  frame_sync_gen dut0 (
    .clk(clk), .rst(rst), .i_rx_start_pulse(st), .i_rx_end_pulse(en),
    .i_bit_valid(bv), .i_bit_data(bd),
    .o_sync_valid_pulse(sv[0]), .o_lost_pulse(lost[0]), .o_bit_data(od[0]),
    .o_bit_valid(ov[0]), .o_frame_start(fs[0]), .o_frame_end(fe[0]),
    .o_locked(lk[0]), .o_polarity(pl[0]), .o_sync_err(er[0]));

  frame_sync_gen #(.POL_DETECT(0)) dut_np (
    .clk(clk), .rst(rst), .i_rx_start_pulse(st), .i_rx_end_pulse(en),
    .i_bit_valid(bv), .i_bit_data(bd),
    .o_sync_valid_pulse(sv[1]), .o_lost_pulse(lost[1]), .o_bit_data(od[1]),
    .o_bit_valid(ov[1]), .o_frame_start(fs[1]), .o_frame_end(fe[1]),
    .o_locked(lk[1]), .o_polarity(pl[1]), .o_sync_err(er[1]));

  frame_sync_gen #(.MAX_ERR(1)) dut_e1 (
    .clk(clk), .rst(rst), .i_rx_start_pulse(st), .i_rx_end_pulse(en),
    .i_bit_valid(bv), .i_bit_data(bd),
    .o_sync_valid_pulse(sv[2]), .o_lost_pulse(lost[2]), .o_bit_data(od[2]),
    .o_bit_valid(ov[2]), .o_frame_start(fs[2]), .o_frame_end(fe[2]),
    .o_locked(lk[2]), .o_polarity(pl[2]), .o_sync_err(er[2]));

  typedef struct packed { logic d; logic s; logic e; } exp_t;
  typedef struct { logic [6:0] word; logic [2:0] lk; logic [2:0] pl; logic [2:0] er1; } vec_t;

  exp_t sbq[$];
  exp_t e_m;
  vec_t tbl[7];
  int n_cmp = 0, n_bad = 0, cnt_np = 0, lost_cnt = 0;

  // Scoreboard side: every forwarded bit of dut0 must match the next queued expectation.
  always @(negedge clk) begin
    if (ov[1]) cnt_np++;
    if (lost[0]) lost_cnt++;
    if (ov[0]) begin
      n_cmp++;
      if (sbq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_bit: o_bit_valid=1 (data %0b) with nothing expected", od[0]);
      end else begin
        e_m = sbq.pop_front();
        if ({od[0], fs[0], fe[0]} !== {e_m.d, e_m.s, e_m.e}) begin
          n_bad++;
          $display("FAIL payload_bit: got d/s/e=%b%b%b expected %b%b%b",
                   od[0], fs[0], fe[0], e_m.d, e_m.s, e_m.e);
        end
      end
    end
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk3(input string nm, input logic [2:0] act, input logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic b, input logic s = 1'b0,
                      input logic e = 1'b0, input logic r = 1'b0);
    @(negedge clk);
    bv = v; bd = b; st = s; en = e; rst = r;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [6:0] w);
    for (int i = 6; i >= 0; i--) step(1'b1, w[i]);
  endtask

  // mode 0: alternating starting with 1, mode 1: all zero, otherwise random
  task automatic send_payload(input int n, input logic pol, input int mode);
    for (int i = 0; i < n; i++) begin
      logic b;
      case (mode)
        0:       b = (i % 2 == 0);
        1:       b = 1'b0;
        default: b = 1'($urandom_range(0, 1));
      endcase
      sbq.push_back(exp_t'{d: b ^ pol, s: (i == 0), e: (i == 63)});
      step(1'b1, b);
    end
  endtask

  initial begin
    logic [6:0] good, bad, inv;
    logic [6:0] words [6];
    logic [10:0] fm;
    int base;
    good = 7'b1110010; bad = 7'b0000000; inv = 7'b0001101;
    rst = 1'b1; st = 1'b0; en = 1'b0; bv = 1'b0; bd = 1'b0;

    // word, lock {e1,np,d0}, polarity {e1,np,d0}, sync_err of MAX_ERR=1 instance
    tbl[0] = '{7'b1110010, 3'b111, 3'b000, 3'd0};
    tbl[1] = '{7'b0001101, 3'b101, 3'b101, 3'd0};
    tbl[2] = '{7'b1110011, 3'b100, 3'b000, 3'd1};
    tbl[3] = '{7'b1110001, 3'b000, 3'b000, 3'd0};
    tbl[4] = '{7'b0001100, 3'b100, 3'b100, 3'd1};
    tbl[5] = '{7'b1010010, 3'b100, 3'b000, 3'd1};
    tbl[6] = '{7'b0000000, 3'b000, 3'b000, 3'd0};

    do_reset();
    chk3("rst_sync", sv, 3'b000);   chk3("rst_lost", lost, 3'b000);
    chk3("rst_bv", ov, 3'b000);     chk3("rst_bd", od, 3'b000);
    chk3("rst_fs", fs, 3'b000);     chk3("rst_fe", fe, 3'b000);
    chk3("rst_lock", lk, 3'b000);   chk3("rst_pol", pl, 3'b000);
    chk3("rst_err0", er[0], 3'd0);

    foreach (tbl[k]) begin
      do_reset();
      step(1'b0, 1'b0, 1'b1);
      send_word(tbl[k].word);
      step(1'b0, 1'b0);
      chk3($sformatf("tbl%0d_sync", k), sv, tbl[k].lk);
      chk3($sformatf("tbl%0d_lock", k), lk, tbl[k].lk);
      chk3($sformatf("tbl%0d_pol", k), pl, tbl[k].pl);
      chk3($sformatf("tbl%0d_err0", k), er[0], 3'd0);
      chk3($sformatf("tbl%0d_err1", k), er[1], 3'd0);
      chk3($sformatf("tbl%0d_err2", k), er[2], tbl[k].er1);
      step(1'b0, 1'b0);
      chk3($sformatf("tbl%0d_pulse_1cyc", k), sv, 3'b000);
    end

    // Basic frame: alternating payload, frame markers on bits 0 and 63
    do_reset();
    step(1'b0, 1'b0, 1'b1);
    send_word(good);
    step(1'b0, 1'b0);
    chk1("t2_sync", sv[0], 1'b1);
    chk1("t2_pol", pl[0], 1'b0);
    send_payload(64, 1'b0, 0);
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    chkn("t2_sb_empty", sbq.size(), 0);
    chk1("t2_locked", lk[0], 1'b1);

    // Inverted sync: all-zero payload comes out as ones; POL_DETECT=0 stays silent
    do_reset();
    base = cnt_np;
    step(1'b0, 1'b0, 1'b1);
    send_word(inv);
    step(1'b0, 1'b0);
    chk1("t3_sync", sv[0], 1'b1);
    chk1("t3_pol", pl[0], 1'b1);
    send_payload(64, 1'b1, 1);
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    chkn("t3_sb_empty", sbq.size(), 0);
    chkn("t3_np_bits", cnt_np - base, 0);
    chk1("t3_np_lock", lk[1], 1'b0);

    // Flywheel: misses, a good sync clearing the count, then loss on the third miss
    do_reset();
    base = lost_cnt;
    words[0] = good; words[1] = bad; words[2] = bad;
    words[3] = good; words[4] = bad; words[5] = bad;
    step(1'b0, 1'b0, 1'b1);
    for (int j = 0; j < 6; j++) begin
      send_word(words[j]);
      send_payload(64, 1'b0, 2);
    end
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    chk1("t4_locked_before", lk[0], 1'b1);
    chkn("t4_no_early_lost", lost_cnt - base, 0);
    chkn("t4_sb_empty", sbq.size(), 0);
    send_word(inv);
    step(1'b0, 1'b0);
    chk1("t4_lost_pulse", lost[0], 1'b1);
    chk1("t4_unlocked", lk[0], 1'b0);
    step(1'b0, 1'b0);
    chk1("t4_lost_1cyc", lost[0], 1'b0);
    repeat (10) step(1'b1, 1'b0);
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    chkn("t4_lost_count", lost_cnt - base, 1);
    chkn("t4_sb_empty2", sbq.size(), 0);

    // End pulse at payload bit 20, then re-acquire without a start pulse
    do_reset();
    base = lost_cnt;
    step(1'b0, 1'b0, 1'b1);
    send_word(good);
    send_payload(20, 1'b0, 2);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk1("t5_unlocked", lk[0], 1'b0);
    repeat (10) step(1'b1, 1'b0);
    send_word(good);
    step(1'b0, 1'b0);
    chk1("t5_reacq_sync", sv[0], 1'b1);
    chk1("t5_reacq_lock", lk[0], 1'b1);
    send_payload(5, 1'b0, 2);
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    chkn("t5_sb_empty", sbq.size(), 0);
    chkn("t5_no_lost", lost_cnt - base, 0);

    // Reset mid-payload, IDLE ignores bits, early-window false match suppressed
    do_reset();
    step(1'b0, 1'b0, 1'b1);
    send_word(inv);
    send_payload(10, 1'b1, 2);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk1("t6_lock", lk[0], 1'b0);    chk1("t6_pol", pl[0], 1'b0);
    chk1("t6_bv", ov[0], 1'b0);      chk1("t6_bd", od[0], 1'b0);
    chk1("t6_fs", fs[0], 1'b0);      chk1("t6_fe", fe[0], 1'b0);
    chk3("t6_err", er[0], 3'd0);     chk3("t6_lock_all", lk, 3'b000);
    send_word(good);
    step(1'b0, 1'b0);
    chk1("t6_idle_sync", sv[0], 1'b0);
    chk1("t6_idle_lock", lk[0], 1'b0);
    step(1'b0, 1'b0, 1'b1);
    fm = 11'b1101_1110010;
    for (int i = 0; i < 11; i++) begin
      step(1'b1, fm[10-i]);
      if (i > 0) chk1($sformatf("t6_nofalse_%0d", i), sv[0], 1'b0);
    end
    step(1'b0, 1'b0);
    chk1("t6_true_sync", sv[0], 1'b1);
    chk1("t6_true_pol", pl[0], 1'b0);
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    chkn("t6_sb_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
